// File: rtl/debounce_pkg.sv
// Shared constants for the push-button debouncer: FSM state encoding and
// the default number of stable samples needed to accept a level change.
package debounce_pkg;

    // Per-channel FSM encoding (2-bit, fixed values)
    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    localparam int STABLE_SAMPLES_DEFAULT = 4;

endpackage

// File: rtl/debounce_chan.sv
// One debounced push-button channel: 2-flop input synchronizer, polarity
// normalisation, accept/reject FSM with stable-sample counter, and
// registered level / press / release outputs.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int STABLE_SAMPLES = STABLE_SAMPLES_DEFAULT,
    parameter bit ACTIVE_LOW     = 1'b1
) (
    input  logic Clk,
    input  logic Reset,
    input  logic SampleStb,
    input  logic BtnRaw,
    output logic BtnLevel,
    output logic BtnPress,
    output logic BtnRelease
);

    localparam int               CNT_W   = $clog2(STABLE_SAMPLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_SAMPLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             raw_meta;
    logic             raw_sync;
    logic             pressed;
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             release_q;

    // Bring the asynchronous pin into the Clk domain
    always_ff @(posedge Clk) begin
        if (Reset) begin
            raw_meta <= 1'b0;
            raw_sync <= 1'b0;
        end else begin
            raw_meta <= BtnRaw;
            raw_sync <= raw_meta;
        end
    end

    assign pressed = ACTIVE_LOW ? ~raw_sync : raw_sync;
    assign cnt_inc = cnt_q + CNT_ONE;

    // Next-state and counter; both only move on a sample strobe
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (SampleStb) begin
            case (state_q)
                ST_IDLE: begin
                    if (pressed) begin
                        if (STABLE_SAMPLES == 1) begin
                            state_d = ST_PRESSED;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_PRESS_WAIT;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!pressed) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_inc == CNT_MAX) begin
                        state_d = ST_PRESSED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end
                ST_PRESSED: begin
                    if (!pressed) begin
                        if (STABLE_SAMPLES == 1) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_RELEASE_WAIT;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (pressed) begin
                        state_d = ST_PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_inc == CNT_MAX) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Level follows the state the FSM is entering, so it lags the strobe by one edge
    assign level_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);

    // FSM state, counter and registered outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            // level_q always mirrors state_q, so an edge on it marks an accepted change
            press_q   <= level_d & ~level_q;
            release_q <= ~level_d & level_q;
        end
    end

    assign BtnLevel   = level_q;
    assign BtnPress   = press_q;
    assign BtnRelease = release_q;

endmodule

// File: rtl/button_debounce.sv
// Multi-channel push-button debouncer. A single sample strobe is derived
// from the divided SlowClock (treated purely as data) and shared by all
// independent per-button channels.
module button_debounce
    import debounce_pkg::*;
#(
    parameter int NUM_BTN        = 4,
    parameter int STABLE_SAMPLES = STABLE_SAMPLES_DEFAULT,
    parameter bit ACTIVE_LOW     = 1'b1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               SlowClock,
    input  logic [NUM_BTN-1:0] BtnRaw,
    output logic [NUM_BTN-1:0] BtnLevel,
    output logic [NUM_BTN-1:0] BtnPress,
    output logic [NUM_BTN-1:0] BtnRelease
);

    logic slow_meta;
    logic slow_sync;
    logic slow_dly;
    logic sample_stb;

    // Synchronize SlowClock and keep one extra stage for rising-edge detection
    always_ff @(posedge Clk) begin
        if (Reset) begin
            slow_meta <= 1'b0;
            slow_sync <= 1'b0;
            slow_dly  <= 1'b0;
        end else begin
            slow_meta <= SlowClock;
            slow_sync <= slow_meta;
            slow_dly  <= slow_sync;
        end
    end

    // High for exactly one Clk cycle per synchronized SlowClock rising edge
    assign sample_stb = slow_sync & ~slow_dly;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        debounce_chan #(
            .STABLE_SAMPLES (STABLE_SAMPLES),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_chan (
            .Clk        (Clk),
            .Reset      (Reset),
            .SampleStb  (sample_stb),
            .BtnRaw     (BtnRaw[i]),
            .BtnLevel   (BtnLevel[i]),
            .BtnPress   (BtnPress[i]),
            .BtnRelease (BtnRelease[i])
        );
    end

endmodule
